// File: rtl/hififo_pkg.sv
// rtl/hififo_pkg.sv - register map, holdoff width default and holdoff FSM states for hififo control
package hififo_pkg;

    localparam int REG_INT_STATUS     = 0;
    localparam int REG_COUNT          = 1;
    localparam int REG_INT_W1C        = 2;
    localparam int REG_FIFO_RESET     = 8;
    localparam int REG_HOLDOFF        = 9;
    localparam int REG_CHAN_BASE      = 16;

    localparam int HOLDOFF_W_DEFAULT  = 16;

    typedef enum logic {
        HO_IDLE = 1'b0,
        HO_HOLD = 1'b1
    } holdoff_state_e;

endpackage

// File: rtl/hififo_irq_holdoff.sv
// rtl/hififo_irq_holdoff.sv - interrupt coalescing: one pulse, then at most one deferred pulse per holdoff window
module hififo_irq_holdoff
    import hififo_pkg::*;
#(
    parameter int HOLDOFF_W = HOLDOFF_W_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 pci_reset,
    input  logic                 pend,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 irq_pulse
);

    holdoff_state_e       state, state_nx;
    logic [HOLDOFF_W-1:0] timer, timer_nx;
    logic                 deferred, deferred_nx;
    logic                 pulse_nx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HO_IDLE;
            timer     <= '0;
            deferred  <= 1'b0;
            irq_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            deferred  <= deferred_nx;
            irq_pulse <= pulse_nx;
        end
    end

    // The window closes in the cycle whose decrement lands on zero, so a
    // holdoff of N spaces consecutive pulses exactly N cycles apart.
    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        deferred_nx = deferred;
        pulse_nx    = 1'b0;
        if (pci_reset) begin
            state_nx    = HO_IDLE;
            timer_nx    = '0;
            deferred_nx = 1'b0;
        end else begin
            case (state)
                HO_IDLE: begin
                    if (pend) begin
                        pulse_nx = 1'b1;
                        timer_nx = holdoff;
                        state_nx = (holdoff != '0) ? HO_HOLD : HO_IDLE;
                    end
                end
                HO_HOLD: begin
                    if (timer <= HOLDOFF_W'(1)) begin
                        if (deferred || pend) begin
                            pulse_nx    = 1'b1;
                            timer_nx    = holdoff;
                            deferred_nx = 1'b0;
                            state_nx    = (holdoff != '0) ? HO_HOLD : HO_IDLE;
                        end else begin
                            timer_nx = '0;
                            state_nx = HO_IDLE;
                        end
                    end else begin
                        timer_nx    = timer - HOLDOFF_W'(1);
                        deferred_nx = deferred | pend;
                    end
                end
                default: state_nx = HO_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hififo_ctrl_regs.sv
// rtl/hififo_ctrl_regs.sv - hififo PIO control/status registers and interrupt logic for NFIFO channels
// Optional feature macro HIFIFO_INT_HOLDOFF_EN adds the holdoff register (address 9) and interrupt coalescing.
module hififo_ctrl_regs
    import hififo_pkg::*;
#(
    parameter int NFIFO     = 2,
    parameter int ADDR_W    = 13,
    parameter int HOLDOFF_W = HOLDOFF_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pci_reset,
    input  logic                  pio_wvalid,
    input  logic                  pio_rvalid,
    input  logic [ADDR_W-1:0]     pio_addr,
    input  logic [63:0]           pio_wdata,
    input  logic [2*NFIFO-1:0]    irq_src,
    input  logic [64*NFIFO-1:0]   chan_status,
    output logic                  rc_done,
    output logic [63:0]           rc_data,
    output logic [NFIFO-1:0]      fifo_reset,
    output logic                  interrupt_out
);

    localparam int NINT = 2 * NFIFO;

    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(REG_INT_STATUS);
    localparam logic [ADDR_W-1:0] A_COUNT   = ADDR_W'(REG_COUNT);
    localparam logic [ADDR_W-1:0] A_W1C     = ADDR_W'(REG_INT_W1C);
    localparam logic [ADDR_W-1:0] A_FRESET  = ADDR_W'(REG_FIFO_RESET);
    localparam logic [ADDR_W-1:0] A_HOLDOFF = ADDR_W'(REG_HOLDOFF);

    logic [NINT-1:0]  irq_src_q;
    logic [NINT-1:0]  status;
    logic [NINT-1:0]  mask;
    logic [NFIFO-1:0] reset_reg;
    logic [63:0]      counter;
    logic [NINT-1:0]  ev;
    logic [NINT-1:0]  clr;
    logic             pend;
    logic [63:0]      rd_val;
    logic             unused_wdata;

    assign unused_wdata = ^pio_wdata;
    assign ev           = irq_src ^ irq_src_q;
    assign pend         = |(mask & ev);

    always_comb begin
        clr = '0;
        if (pio_rvalid && pio_addr == A_STATUS) begin
            clr = '1;
        end else if (pio_wvalid && pio_addr == A_W1C) begin
            clr = pio_wdata[NINT-1:0];
        end
    end

`ifdef HIFIFO_INT_HOLDOFF_EN
    logic [HOLDOFF_W-1:0] holdoff_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            holdoff_reg <= '0;
        end else if (pio_wvalid && pio_addr == A_HOLDOFF) begin
            holdoff_reg <= pio_wdata[HOLDOFF_W-1:0];
        end
    end

    hififo_irq_holdoff #(
        .HOLDOFF_W (HOLDOFF_W)
    ) u_holdoff (
        .clock     (clock),
        .reset_n   (reset_n),
        .pci_reset (pci_reset),
        .pend      (pend),
        .holdoff   (holdoff_reg),
        .irq_pulse (interrupt_out)
    );
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            interrupt_out <= 1'b0;
        end else begin
            interrupt_out <= pend;
        end
    end
`endif

    // Read mux sees pre-write register values, so a same-cycle write never leaks into the completion.
    always_comb begin
        rd_val = '0;
        case (pio_addr)
            A_STATUS:  rd_val = 64'(status);
            A_COUNT:   rd_val = counter;
            A_FRESET:  rd_val = 64'(reset_reg);
`ifdef HIFIFO_INT_HOLDOFF_EN
            A_HOLDOFF: rd_val = 64'(holdoff_reg);
`endif
            default:   rd_val = '0;
        endcase
        for (int k = 0; k < NFIFO; k++) begin
            if (pio_addr == ADDR_W'(REG_CHAN_BASE + k)) begin
                rd_val = chan_status[64*k +: 64];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_src_q  <= '0;
            status     <= '0;
            mask       <= '0;
            reset_reg  <= '1;
            counter    <= '0;
            fifo_reset <= '1;
            rc_done    <= 1'b0;
            rc_data    <= '0;
        end else begin
            irq_src_q  <= irq_src;
            counter    <= counter + 64'd1;
            status     <= pci_reset ? '0 : ((status & ~clr) | ev);
            if (pio_wvalid && pio_addr == A_STATUS) begin
                mask <= pio_wdata[NINT-1:0];
            end
            if (pio_wvalid && pio_addr == A_FRESET) begin
                reset_reg <= pio_wdata[NFIFO-1:0];
            end
            fifo_reset <= pci_reset ? '1 : reset_reg;
            rc_done    <= pio_rvalid;
            if (pio_rvalid) begin
                rc_data <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_hififo_ctrl_regs.sv
// tb/tb_hififo_ctrl_regs.sv - self-checking bench for hififo_ctrl_regs (NFIFO=4), directed plus random steps
module tb_hififo_ctrl_regs;

    localparam int NF = 4;
    localparam int NI = 2 * NF;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            pci_reset = 1'b0;
    logic            pio_wvalid = 1'b0;
    logic            pio_rvalid = 1'b0;
    logic [12:0]     pio_addr = '0;
    logic [63:0]     pio_wdata = '0;
    logic [NI-1:0]   irq_src = '0;
    logic [64*NF-1:0] chan_status = '0;
    logic            rc_done;
    logic [63:0]     rc_data;
    logic [NF-1:0]   fifo_reset;
    logic            interrupt_out;

    hififo_ctrl_regs #(.NFIFO(NF)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pci_reset     (pci_reset),
        .pio_wvalid    (pio_wvalid),
        .pio_rvalid    (pio_rvalid),
        .pio_addr      (pio_addr),
        .pio_wdata     (pio_wdata),
        .irq_src       (irq_src),
        .chan_status   (chan_status),
        .rc_done       (rc_done),
        .rc_data       (rc_data),
        .fifo_reset    (fifo_reset),
        .interrupt_out (interrupt_out)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [NI-1:0] m_status, m_mask, m_prev;
    logic [NF-1:0] m_rst;
    logic [63:0]   m_cnt;
    logic [15:0]   m_hold;
    logic [63:0]   last_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [12:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0) return 64'(m_status);
        if (ai == 1) return m_cnt;
        if (ai == 8) return 64'(m_rst);
`ifdef HIFIFO_INT_HOLDOFF_EN
        if (ai == 9) return 64'(m_hold);
`endif
        if (ai >= 16 && ai < 16 + NF) return chan_status[(ai-16)*64 +: 64];
        return 64'd0;
    endfunction

    task automatic model_reset();
        m_status = '0;
        m_mask   = '0;
        m_prev   = '0;
        m_rst    = '1;
        m_cnt    = '0;
        m_hold   = '0;
    endtask

    // One clock: predict from the rules, advance the model, then compare after the edge.
    task automatic step(input bit chk_irq = 1'b1);
        logic [63:0]   e_data;
        logic          e_done, e_irq;
        logic [NF-1:0] e_fr;
        logic [NI-1:0] ev, clr;
        e_done = pio_rvalid;
        e_data = model_read(pio_addr);
        ev     = irq_src ^ m_prev;
`ifdef HIFIFO_INT_HOLDOFF_EN
        e_irq  = ((m_mask & ev) != 0) && !pci_reset;
`else
        e_irq  = ((m_mask & ev) != 0);
`endif
        e_fr   = pci_reset ? '1 : m_rst;
        clr    = '0;
        if (pio_rvalid && pio_addr == 13'd0) clr = '1;
        else if (pio_wvalid && pio_addr == 13'd2) clr = pio_wdata[NI-1:0];
        m_status = pci_reset ? '0 : ((m_status & ~clr) | ev);
        if (pio_wvalid && pio_addr == 13'd0) m_mask = pio_wdata[NI-1:0];
        if (pio_wvalid && pio_addr == 13'd8) m_rst = pio_wdata[NF-1:0];
`ifdef HIFIFO_INT_HOLDOFF_EN
        if (pio_wvalid && pio_addr == 13'd9) m_hold = pio_wdata[15:0];
`endif
        m_prev = irq_src;
        m_cnt  = m_cnt + 64'd1;
        @(posedge clock);
        #1;
        chk("rc_done", 64'(rc_done), 64'(e_done));
        if (e_done) begin
            chk("rc_data", rc_data, e_data);
            last_rd = rc_data;
        end
        if (chk_irq) chk("interrupt_out", 64'(interrupt_out), 64'(e_irq));
        chk("fifo_reset", 64'(fifo_reset), 64'(e_fr));
        pio_rvalid = 1'b0;
        pio_wvalid = 1'b0;
        pci_reset  = 1'b0;
    endtask

    task automatic rd(input int a);
        pio_rvalid = 1'b1;
        pio_addr   = 13'(a);
        step();
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        pio_wvalid = 1'b1;
        pio_addr   = 13'(a);
        pio_wdata  = d;
        step();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        pio_rvalid = 1'b0;
        pio_wvalid = 1'b0;
        pci_reset  = 1'b0;
        irq_src    = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_rc_done", 64'(rc_done), 64'd0);
        chk("reset_rc_data", rc_data, 64'd0);
        chk("reset_fifo_reset", 64'(fifo_reset), 64'hF);
        chk("reset_irq", 64'(interrupt_out), 64'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] c1;
        int addrs [12] = '{0, 1, 2, 8, 9, 16, 17, 18, 19, 20, 3, 40};
        int a;

        do_reset();

        rd(1); c1 = last_rd;
        rd(1);
        chk("count_increases", 64'(last_rd > c1), 64'd1);
        rd(0); chk("status_after_reset", last_rd, 64'd0);

        wr(0, 64'hF);
        irq_src[2] = ~irq_src[2];
        step();
        chk("irq_pulse_high", 64'(interrupt_out), 64'd1);
        step();
        chk("irq_pulse_low", 64'(interrupt_out), 64'd0);
        rd(0); chk("status_0x4", last_rd, 64'h4);
        rd(0); chk("status_cleared", last_rd, 64'h0);

        irq_src[3] = ~irq_src[3];
        step();
        irq_src[1] = ~irq_src[1];
        rd(0); chk("race_old_value", last_rd, 64'h8);
        rd(0); chk("race_event_kept", last_rd, 64'h2);
        irq_src[1] = ~irq_src[1];
        irq_src[0] = ~irq_src[0];
        step();
        wr(2, 64'h1);
        rd(0); chk("w1c_partial", last_rd, 64'h2);
        irq_src[1] = ~irq_src[1];
        step();
        wr(2, 64'h2);
        rd(0); chk("w1c_cleared", last_rd, 64'h0);

        wr(8, 64'h0);
        step();
        chk("fifo_reset_released", 64'(fifo_reset), 64'h0);
        pci_reset = 1'b1;
        step();
        chk("pci_reset_forces", 64'(fifo_reset), 64'hF);
        step();
        chk("pci_reset_back", 64'(fifo_reset), 64'h0);
        rd(8); chk("reset_reg_read", last_rd, 64'h0);

`ifdef HIFIFO_INT_HOLDOFF_EN
        wr(9, 64'd10);
        rd(9); chk("holdoff_read", last_rd, 64'd10);
        for (int t = 0; t < 15; t++) begin
            if (t == 0 || t == 3 || t == 5) irq_src[0] = ~irq_src[0];
            step(1'b0);
            chk($sformatf("holdoff_t%0d", t + 1), 64'(interrupt_out),
                64'((t == 0) || (t == 10)));
        end
        pci_reset = 1'b1;
        step();
        wr(9, 64'd0);
`else
        wr(9, 64'd10);
        rd(9); chk("holdoff_absent", last_rd, 64'd0);
`endif

        chan_status[3*64 +: 64] = 64'hDEADBEEF;
        rd(19); chk("chan3_status", last_rd, 64'hDEADBEEF);
        rd(20); chk("chan_unmapped", last_rd, 64'h0);

        for (int i = 0; i < 400; i++) begin
            a = addrs[$urandom_range(0, 11)];
            pio_addr   = 13'(a);
            pio_rvalid = ($urandom_range(0, 1) == 1);
            pio_wvalid = ($urandom_range(0, 2) == 0) && (a != 9);
            pio_wdata  = {$urandom, $urandom};
            pci_reset  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ NI'($urandom);
            chan_status[$urandom_range(0, NF-1)*64 +: 64] = {$urandom, $urandom};
            step();
        end

        pio_rvalid = 1'b1;
        pio_addr   = 13'd1;
        @(posedge clock);
        #1;
        pio_rvalid = 1'b0;
        chk("inflight_done", 64'(rc_done), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("inflight_dropped", 64'(rc_done), 64'd0);
        do_reset();
        rd(0); chk("status_after_midreset", last_rd, 64'd0);
        rd(8); chk("reset_reg_after_midreset", last_rd, 64'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hififo_ctrl_regs.md
# hififo_ctrl_regs

Parametrised control/status register and interrupt block for the hififo PCIe engine. It sits between the PCIe RX/TX pair and NFIFO stream FIFOs. It decodes PIO writes and reads, owns the per-FIFO reset register, the sticky interrupt status, the interrupt mask and a free-running cycle counter, and produces the read-completion data for TX. It generalises the fixed one-FPC/one-TPC control logic to NFIFO channels and adds interrupt holdoff (coalescing) and write-1-to-clear status.

## Interface
- NFIFO, 2, number of FIFO channels (1..8); each channel has 2 interrupt sources, so NINT = 2*NFIFO.
- ADDR_W, 13, PIO address width.
- HOLDOFF_W, 16, width of the interrupt holdoff counter.

- clock  in  1  PCIe user clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pci_reset  in  1  synchronous, active-high link reset; forces all FIFO resets and clears status.
- pio_wvalid  in  1  PIO write strobe.
- pio_rvalid  in  1  PIO read request strobe.
- pio_addr  in  ADDR_W  PIO address, in 64-bit words.
- pio_wdata  in  64  PIO write data.
- irq_src  in  NINT  interrupt source levels; any toggle is an event.
- chan_status  in  64*NFIFO  per-channel status words; channel k occupies [64k+63:64k].
- rc_done  out  1  read completion valid.
- rc_data  out  64  read completion data.
- fifo_reset  out  NFIFO  per-channel FIFO reset, active high.
- interrupt_out  out  1  single-cycle interrupt request pulse to the core.

## Operation
- Register map (word addresses):
  - 0: read returns interrupt status, then clears it. Write sets interrupt mask[NINT-1:0].
  - 1: read returns the 64-bit counter.
  - 2: write clears status bits where wdata=1 (W1C).
  - 8: read/write FIFO reset register[NFIFO-1:0].
  - 9: read/write holdoff[HOLDOFF_W-1:0], only when the holdoff feature is compiled in.
  - 16+k: read returns chan_status of channel k.
- Unmapped reads return 0. Unmapped writes are ignored. Narrow registers are zero-extended on read.
- Event: ev = irq_src ^ irq_src_q, where irq_src_q is the previous-cycle sample.
- Status: status <= (status & ~clear) | ev.
  - clear is all ones on a read of address 0, or wdata on a W1C write.
  - An event in the same cycle as a clear remains set.
  - pci_reset forces status to 0; pci_reset takes priority over ev.
- Interrupt pending: pend = |(mask & ev).
- Counter: increments every cycle and wraps from 2^64-1 to 0. It is not affected by pci_reset.
- fifo_reset <= pci_reset ? all ones : reset register. The reset register itself is unchanged by pci_reset.
- If pio_wvalid and pio_rvalid occur on the same address in the same cycle, the read returns the pre-write value.

## Timing
- Reset values: rc_done=0, rc_data=0, interrupt_out=0, fifo_reset=all ones, reset register=all ones, mask=0, status=0, counter=0, holdoff=0, irq_src_q=0.
- Read latency is 1 cycle: rc_done is high for exactly one cycle, the cycle after pio_rvalid, with rc_data valid in that cycle. Back-to-back reads give back-to-back completions.
- A write takes effect in the next cycle. fifo_reset follows a write to address 8 or assertion of pci_reset after one further registered cycle.
- interrupt_out (without holdoff): goes high the cycle after ev is sampled with pend=1.
- Holdoff state machine, states IDLE/HOLD:
  - IDLE & pend: pulse interrupt_out, load timer with holdoff. Go to HOLD if holdoff≠0, otherwise stay in IDLE.
  - HOLD: decrement the timer. pend sets a deferred flag.
  - Timer reaches 0: if deferred, pulse, reload the timer, clear deferred and stay in HOLD; otherwise go to IDLE.
  - pci_reset → IDLE, timer=0, deferred=0.
- A mid-operation assertion of reset_n clears everything asynchronously. A completion in flight is dropped (rc_done stays 0).

## Configuration
- HIFIFO_INT_HOLDOFF_EN
  - Defined: the holdoff register at address 9 and the IDLE/HOLD coalescing described above are present.
  - Undefined: interrupt_out <= pend every cycle; address 9 reads 0 and writes are ignored; the timer logic is absent.

## Structure
- hififo_pkg holds the register address localparams (REG_INT_STATUS=0, REG_COUNT=1, REG_INT_W1C=2, REG_FIFO_RESET=8, REG_HOLDOFF=9, REG_CHAN_BASE=16) and the HOLDOFF_W default.
- Sub-module hififo_irq_holdoff contains the IDLE/HOLD state machine and timer. It is instantiated only under HIFIFO_INT_HOLDOFF_EN.

## Test plan
- Reset: release reset_n → fifo_reset=2'b11, interrupt_out=0. A read of address 1 returns a small value that increases on a second read; a read of address 0 returns 0.
- Mask and interrupt: write 0xF to address 0, then toggle irq_src[2] → exactly one interrupt_out pulse, 1 cycle later. A read of address 0 returns 0x4; the next read returns 0.
- Clear race: toggle irq_src[1] in the same cycle as a read of address 0 → that read returns the old value, and the next read returns 0x2. A W1C write of 0x2 clears it.
- FIFO reset: write 0 to address 8 → fifo_reset=0 two cycles later. Pulse pci_reset → fifo_reset=all ones for one cycle, then back to 0. A read of address 8 returns 0.
- Holdoff (macro defined): write 10 to address 9, then toggle an unmasked source at t=0, 3 and 5 → interrupt_out pulses at t=1 and at t=11 only.
- Channel status with NFIFO=4: drive chan_status channel 3 with 0xDEADBEEF → a read of address 19 returns 0xDEADBEEF; a read of address 20 returns 0.
